mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: HI/LO registers, multi-cycle busy timing and pipeline stall.
// Optional divider enabled by defining MDU_DIV_EN; without it div/divu are no-ops.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          uns_q, uns_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [63:0]   ext_a, ext_b, res;
  logic          res_we;
  logic          long_op;
`ifdef MDU_DIV_EN
  logic          is_div_q, is_div_d;
  logic [31:0]   abs_a, abs_b, quo, rem;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      uns_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      uns_q   <= uns_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  // Result datapath, fed only by the operands latched at issue
  always_comb begin
    ext_a  = uns_q ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
    ext_b  = uns_q ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
    res    = ext_a * ext_b;
    res_we = 1'b1;
`ifdef MDU_DIV_EN
    // Signed divide on magnitudes; quotient truncates to zero, remainder follows the dividend
    abs_a = (!uns_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    abs_b = (!uns_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    quo   = (b_q != 32'd0) ? (abs_a / abs_b) : 32'd0;
    rem   = (b_q != 32'd0) ? (abs_a % abs_b) : 32'd0;
    if (is_div_q) begin
      res_we = (b_q != 32'd0);
      res    = {((!uns_q && a_q[31]) ? (32'd0 - rem) : rem),
                ((!uns_q && (a_q[31] ^ b_q[31])) ? (32'd0 - quo) : quo)};
    end else begin
      res_we = 1'b1;
    end
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    uns_d   = uns_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              a_d     = rs_data;
              b_d     = rt_data;
              uns_d   = op[0];
              cnt_d   = CW'(MULT_CYCLES);
              state_d = BUSY;
`ifdef MDU_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef MDU_DIV_EN
            3'd2, 3'd3: begin
              a_d      = rs_data;
              b_d      = rt_data;
              uns_d    = op[0];
              is_div_d = 1'b1;
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = BUSY;
            end
`endif
            3'd4:    hi_d = rs_data;
            3'd5:    lo_d = rs_data;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (res_we) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
          end else begin
            hi_d = hi_q;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == BUSY);
`ifdef MDU_DIV_EN
    long_op = (op <= 3'd3);
`else
    long_op = (op <= 3'd1);
`endif
    stall = d_md & (busy | (start & long_op));
    case (op)
      3'd6:    rd_data = hi_q;
      3'd7:    rd_data = lo_q;
      default: rd_data = 32'd0;
    endcase
  end

endmodule
